uart_tx_periph: RTL and testbench

Memory-mapped 8N1 UART transmitter on the core data bus, sitting downstream of the core's data port alongside the SRAM. The system address decoder routes its window here. Software writes bytes into a small TX FIFO. A baud-rate counter and a frame FSM serialise each byte onto `tx_o`, LSB first. Status and clock-divider registers are readable over the same req/gnt/rvalid protocol the SRAM uses.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 45 ++++
 rtl/uart_tx_periph.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_periph.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Register map, STATUS bit positions and frame states shared by the UART TX block.
package uart_pkg;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_CLKDIV = 2'd2;
    localparam logic [1:0] UART_RSVD   = 2'd3;

    localparam int unsigned STATUS_FULL     = 0;
    localparam int unsigned STATUS_EMPTY    = 1;
    localparam int unsigned STATUS_BUSY     = 2;
    localparam int unsigned STATUS_OVERFLOW = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module uart_tx_fifo #(
    parameter int unsigned FifoDepth = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(FifoDepth);
    localparam logic [AW:0] PtrOne = 1;

    logic [7:0]  mem [FifoDepth];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still lands when a pop frees the slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PtrOne;
            if (do_pop)  rptr <= rptr + PtrOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: bus register file, TX FIFO, baud counter and frame FSM.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int unsigned FifoDepth   = 8,
    parameter logic [15:0] ClkDivReset = 16'd867
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        tx_o
);

    logic [1:0]     reg_sel;
    logic           wr_txdata;
    logic           clr_overflow;
    logic           wr_clkdiv;
    logic [15:0]    clkdiv_q;
    logic           overflow_q;
    uart_tx_state_e state_q;
    logic [15:0]    baud_cnt_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     shift_q;
    logic           tx_q;
    logic           bit_end;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_rdata;
    logic [31:0]    status;
    logic [31:0]    rdata_d;
    logic           unused_ok;

    assign unused_ok = ^{addr_i[31:4], addr_i[1:0], be_i[3:2], wdata_i[31:16]};

    assign reg_sel      = addr_i[3:2];
    assign gnt_o        = req_i;
    assign wr_txdata    = req_i && we_i && be_i[0] && (reg_sel == UART_TXDATA);
    assign clr_overflow = req_i && we_i && be_i[0] && (reg_sel == UART_STATUS) && wdata_i[3];
    assign wr_clkdiv    = req_i && we_i && (reg_sel == UART_CLKDIV);
    assign bit_end      = (baud_cnt_q == '0);
    assign fifo_pop     = !fifo_empty && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end));
    assign tx_o         = tx_q;

    uart_tx_fifo #(
        .FifoDepth(FifoDepth)
    ) u_fifo (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .push (wr_txdata),
        .pop  (fifo_pop),
        .wdata(wdata_i[7:0]),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        status                  = '0;
        status[STATUS_FULL]     = fifo_full;
        status[STATUS_EMPTY]    = fifo_empty;
        status[STATUS_BUSY]     = (state_q != ST_IDLE);
        status[STATUS_OVERFLOW] = overflow_q;
        rdata_d                 = '0;
        if (!we_i) begin
            case (reg_sel)
                UART_STATUS: rdata_d = status;
                UART_CLKDIV: rdata_d = {16'h0000, clkdiv_q};
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= req_i;
            err_o    <= req_i && (reg_sel == UART_RSVD);
            rdata_o  <= req_i ? rdata_d : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clkdiv_q   <= ClkDivReset;
            overflow_q <= 1'b0;
        end else begin
            if (wr_clkdiv && be_i[0]) clkdiv_q[7:0]  <= wdata_i[7:0];
            if (wr_clkdiv && be_i[1]) clkdiv_q[15:8] <= wdata_i[15:8];
            if (wr_txdata && fifo_full && !fifo_pop) overflow_q <= 1'b1;
            else if (clr_overflow)                   overflow_q <= 1'b0;
        end
    end

    // Every bit boundary reloads from clkdiv_q, so divider writes apply at the next bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        state_q    <= ST_START;
                        shift_q    <= fifo_rdata;
                        baud_cnt_q <= clkdiv_q;
                        tx_q       <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state_q    <= ST_DATA;
                        tx_q       <= shift_q[0];
                        shift_q    <= shift_q >> 1;
                        bit_idx_q  <= '0;
                        baud_cnt_q <= clkdiv_q;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt_q <= clkdiv_q;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (fifo_pop) begin
                            state_q    <= ST_START;
                            shift_q    <= fifo_rdata;
                            baud_cnt_q <= clkdiv_q;
                            tx_q       <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: register table, bus response scoreboard, serial line checks.
module tb_uart_tx_periph;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        tx;

    int errors = 0;
    int checks = 0;
    logic        req_d = 1'b0;
    logic [32:0] exp_q [$];

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    uart_tx_periph #(
        .FifoDepth(8),
        .ClkDivReset(16'd867)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .we_i    (we),
        .be_i    (be),
        .addr_i  (addr),
        .wdata_i (wdata),
        .gnt_o   (gnt),
        .rvalid_o(rvalid),
        .rdata_o (rdata),
        .err_o   (err),
        .tx_o    (tx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                              input logic [3:0] b, input logic [31:0] exp_rd);
        addr  = a;
        we    = w;
        wdata = d;
        be    = b;
        req   = 1'b1;
        exp_q.push_back({(a[3:2] == 2'd3), (w ? 32'h0 : exp_rd)});
        #1 check_bit("gnt", gnt, 1'b1);
        @(posedge clk);
        #1;
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic check_idle(input int unsigned n, input string name);
        repeat (n) begin
            @(negedge clk);
            check_bit(name, tx, 1'b1);
        end
    endtask

    // Bits 0..nslow-1 of the 10-bit frame last pslow cycles, the rest pfast cycles.
    task automatic check_frame(input logic [7:0] data, input int unsigned nslow,
                               input int unsigned pslow, input int unsigned pfast);
        logic [9:0] line;
        line = {1'b1, data, 1'b0};
        for (int unsigned b = 0; b < 10; b++) begin
            int unsigned n;
            n = (b < nslow) ? pslow : pfast;
            for (int unsigned c = 0; c < n; c++) begin
                @(negedge clk);
                check_bit($sformatf("tx_byte%02h_bit%0d", data, b), tx, line[b]);
            end
        end
    endtask

    always @(posedge clk) req_d <= rst ? 1'b0 : req;

    always @(negedge clk) begin : monitor
        logic [32:0] e;
        if (req_d || rvalid) check_bit("rvalid_timing", rvalid, req_d);
        if (rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: response 0x%0h with nothing expected at %0t", rdata, $time);
            end else begin
                e = exp_q.pop_front();
                check("rdata", rdata, e[31:0]);
                check_bit("err", err, e[32]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d [10];

        vecs[0]  = '{32'h0000_0000, 1'b0, 32'h0,         4'h0, 32'h0};
        vecs[1]  = '{32'h0000_0004, 1'b0, 32'h0,         4'h0, 32'h2};
        vecs[2]  = '{32'h0000_0008, 1'b0, 32'h0,         4'h0, 32'd867};
        vecs[3]  = '{32'h0000_000C, 1'b0, 32'h0,         4'h0, 32'h0};
        vecs[4]  = '{32'h0000_000C, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vecs[5]  = '{32'h0000_0008, 1'b0, 32'h0,         4'h0, 32'd867};
        vecs[6]  = '{32'h0000_0008, 1'b1, 32'h0000_ABCD, 4'h1, 32'h0};
        vecs[7]  = '{32'h0000_0008, 1'b0, 32'h0,         4'h0, 32'h0000_03CD};
        vecs[8]  = '{32'h0000_0008, 1'b1, 32'h0000_1200, 4'h2, 32'h0};
        vecs[9]  = '{32'h0000_0008, 1'b0, 32'h0,         4'h0, 32'h0000_12CD};
        vecs[10] = '{32'h0000_0008, 1'b1, 32'hFFFF_0003, 4'h3, 32'h0};
        vecs[11] = '{32'h0000_0008, 1'b0, 32'h0,         4'h0, 32'h3};
        vecs[12] = '{32'h0000_0004, 1'b1, 32'h0,         4'h1, 32'h0};
        vecs[13] = '{32'h0000_0106, 1'b0, 32'h0,         4'h0, 32'h2};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_bit("reset_tx", tx, 1'b1);
        check_bit("reset_rvalid", rvalid, 1'b0);
        check_bit("reset_err", err, 1'b0);
        check("reset_rdata", rdata, 32'h0);

        for (int i = 0; i < 14; i++)
            bus_access(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].be, vecs[i].exp);
        wait_cycles(2);

        // Single frame 0xA5 at 4 cycles per bit
        fork
            begin
                check_idle(2, "idle_before_a5");
                check_frame(8'hA5, 10, 4, 4);
                check_idle(1, "idle_after_a5");
            end
            bus_access(32'h0, 1'b1, 32'h0000_00A5, 4'h1, 32'h0);
        join
        bus_access(32'h4, 1'b0, 32'h0, 4'h0, 32'h2);
        wait_cycles(2);

        // Three back-to-back frames with busy sampled in each
        fork
            begin
                check_idle(2, "idle_before_burst");
                check_frame(8'h3C, 10, 4, 4);
                check_frame(8'h81, 10, 4, 4);
                check_frame(8'hFF, 10, 4, 4);
                check_idle(1, "idle_after_burst");
            end
            begin
                bus_access(32'h0, 1'b1, 32'h3C, 4'h1, 32'h0);
                bus_access(32'h0, 1'b1, 32'h81, 4'h1, 32'h0);
                bus_access(32'h0, 1'b1, 32'hFF, 4'h1, 32'h0);
                wait_cycles(7);
                bus_access(32'h4, 1'b0, 32'h0, 4'h0, 32'h4);
                wait_cycles(39);
                bus_access(32'h4, 1'b0, 32'h0, 4'h0, 32'h4);
                wait_cycles(39);
                bus_access(32'h4, 1'b0, 32'h0, 4'h0, 32'h6);
                wait_cycles(34);
                bus_access(32'h4, 1'b0, 32'h0, 4'h0, 32'h2);
            end
        join
        wait_cycles(2);

        // Overflow: first byte in flight, 8 fill the FIFO, the next is dropped;
        // later a push coinciding with the stop-bit pop is accepted while full.
        for (int i = 0; i < 9; i++) d[i] = 8'h10 + 8'(i);
        d[9] = 8'hEE;
        fork
            begin
                check_idle(2, "idle_before_fill");
                for (int i = 0; i < 9; i++) check_frame(d[i], 10, 4, 4);
                check_frame(8'h77, 10, 4, 4);
                check_idle(1, "idle_after_fill");
            end
            begin
                for (int i = 0; i < 10; i++) bus_access(32'h0, 1'b1, {24'h0, d[i]}, 4'h1, 32'h0);
                bus_access(32'h4, 1'b0, 32'h0, 4'h0, 32'hD);
                bus_access(32'h4, 1'b1, 32'h8, 4'h1, 32'h0);
                bus_access(32'h4, 1'b0, 32'h0, 4'h0, 32'h5);
                wait_cycles(28);
                bus_access(32'h0, 1'b1, 32'h77, 4'h1, 32'h0);
                bus_access(32'h4, 1'b0, 32'h0, 4'h0, 32'h5);
            end
        join
        bus_access(32'h4, 1'b0, 32'h0, 4'h0, 32'h2);
        wait_cycles(2);

        // CLKDIV 3 -> 1 written during data bit 0
        fork
            begin
                check_idle(2, "idle_before_div");
                check_frame(8'h5A, 2, 4, 2);
                check_idle(1, "idle_after_div");
            end
            begin
                bus_access(32'h0, 1'b1, 32'h5A, 4'h1, 32'h0);
                wait_cycles(6);
                bus_access(32'h8, 1'b1, 32'h1, 4'h3, 32'h0);
            end
        join
        bus_access(32'h8, 1'b1, 32'h3, 4'h3, 32'h0);
        bus_access(32'h8, 1'b0, 32'h0, 4'h0, 32'h3);
        wait_cycles(2);

        // Reset mid-frame with a second byte queued
        bus_access(32'h0, 1'b1, 32'h33, 4'h1, 32'h0);
        bus_access(32'h0, 1'b1, 32'h44, 4'h1, 32'h0);
        wait_cycles(15);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_bit("tx_after_rst", tx, 1'b1);
        bus_access(32'h4, 1'b0, 32'h0, 4'h0, 32'h2);
        bus_access(32'h8, 1'b0, 32'h0, 4'h0, 32'd867);
        check_idle(60, "idle_after_rst");

        check("sb_drain", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
